// File: rtl/wave_display_reader.sv
// wave_display_reader: read side of the dual-buffer waveform display.
// Walks the captured half of the sample RAM as the raster crosses the waveform
// window, turns each sample into a lit row range and drives the pixel colour.
// wave_display_idle tells the capture side when a buffer swap is safe.
module wave_display_reader #(
  parameter logic [10:0] X_MIN = 11'd64,
  parameter logic [9:0]  Y_MIN = 10'd112,
  parameter logic [23:0] COLOR = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        valid,
  input  logic        read_index,
  input  logic [7:0]  read_value,
  output logic [8:0]  read_address,
  output logic        wave_display_idle,
  output logic        valid_pixel,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  typedef enum logic {S_WAIT, S_DRAW} state_t;

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] c);
    return (a < c) ? a : c;
  endfunction

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] c);
    return (a > c) ? a : c;
  endfunction

  state_t      state_q, state_d;
  logic        idx_q, idx_d;

  logic [10:0] dx;
  logic [9:0]  dy;
  logic        in_x, in_y, win, first, chg;
  logic [7:0]  smp, row;

  logic [8:0]  read_address_q, read_address_d;
  logic [7:0]  last_smp_q, last_smp_d;
  logic        vld_p1_q, vld_p1_d;
  logic        win_p1_q, win_p1_d;
  logic [7:0]  row_p1_q, row_p1_d;
  logic        first_p1_q, first_p1_d;
  logic        chg_p1_q, chg_p1_d;

  logic [7:0]  cur, lo, hi;
  logic        lit;
  logic [7:0]  prev_q, prev_d;
  logic        vld_p2_q, vld_p2_d;
  logic [23:0] rgb_q, rgb_d;

  // Window decode; subtraction wraps so columns/rows left of or above the window fall out too.
  assign dx    = x - X_MIN;
  assign dy    = y - Y_MIN;
  assign in_x  = (dx < 11'd512);
  assign in_y  = (dy < 10'd256);
  assign win   = valid & in_x & in_y;
  assign smp   = dx[8:1];
  assign row   = dy[7:0];
  assign first = (x == X_MIN);
  assign chg   = first | (smp != last_smp_q);

  // Frame FSM: latch the buffer index on window-row entry, hold it until the rows are left.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_WAIT: begin
        if (valid && in_y) begin
          state_d = S_DRAW;
          idx_d   = read_index;
        end
      end
      S_DRAW: begin
        if (valid && !in_y) begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Stage 1: issue the RAM address and carry the pixel context alongside the read.
  always_comb begin
    read_address_d = read_address_q;
    last_smp_d     = last_smp_q;
    if (win) begin
      read_address_d = {idx_d, smp};
      last_smp_d     = smp;
    end
    vld_p1_d   = valid;
    win_p1_d   = win;
    row_p1_d   = row;
    first_p1_d = first;
    chg_p1_d   = win & chg;
  end

  // Stage 2: sample arrives; light rows between the previous and current sample values.
  always_comb begin
    cur = 8'd255 - read_value;
    if (first_p1_q) begin
      lo = cur;
      hi = cur;
    end else begin
      lo = min8(prev_q, cur);
      hi = max8(prev_q, cur);
    end
    lit      = win_p1_q & (row_p1_q >= lo) & (row_p1_q <= hi);
    prev_d   = (win_p1_q && chg_p1_q) ? cur : prev_q;
    vld_p2_d = vld_p1_q;
    rgb_d    = lit ? COLOR : 24'h0;
  end

  // State and pipeline registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_WAIT;
      idx_q          <= 1'b0;
      read_address_q <= 9'd0;
      last_smp_q     <= 8'd0;
      vld_p1_q       <= 1'b0;
      win_p1_q       <= 1'b0;
      row_p1_q       <= 8'd0;
      first_p1_q     <= 1'b0;
      chg_p1_q       <= 1'b0;
      prev_q         <= 8'd0;
      vld_p2_q       <= 1'b0;
      rgb_q          <= 24'h0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      // stage 1 boundary
      read_address_q <= read_address_d;
      last_smp_q     <= last_smp_d;
      vld_p1_q       <= vld_p1_d;
      win_p1_q       <= win_p1_d;
      row_p1_q       <= row_p1_d;
      first_p1_q     <= first_p1_d;
      chg_p1_q       <= chg_p1_d;
      // stage 2 boundary
      prev_q         <= prev_d;
      vld_p2_q       <= vld_p2_d;
      rgb_q          <= rgb_d;
    end
  end

  assign read_address      = read_address_q;
  assign wave_display_idle = (state_q == S_WAIT);
  assign valid_pixel       = vld_p2_q;
  assign r                 = rgb_q[23:16];
  assign g                 = rgb_q[15:8];
  assign b                 = rgb_q[7:0];

endmodule

// File: tb/tb_wave_display_reader.sv
// Bench for wave_display_reader: raster rows over a modelled sample RAM, with a
// pixel-level reference of which rows each column should light.
module tb_wave_display_reader;

  localparam int XMIN = 64;
  localparam int YMIN = 112;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic [7:0]  read_value;
  logic [8:0]  read_address;
  logic        idle;
  logic        valid_pixel;
  logic [7:0]  r, g, b;

  always #5 clk = ~clk;

  wave_display_reader dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .valid(valid),
    .read_index(read_index), .read_value(read_value),
    .read_address(read_address), .wave_display_idle(idle),
    .valid_pixel(valid_pixel), .r(r), .g(g), .b(b)
  );

  // Sample RAM: output for the address registered on the previous edge.
  logic [7:0] mem [2][256];
  assign read_value = mem[read_address[8]][read_address[7:0]];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit vld;
    bit lit;
    int px;
  } exp_t;

  exp_t       pipe_q[$];
  bit         m_draw;
  bit         m_idx;
  logic [8:0] m_addr;
  bit         obs_row [2048];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // A column shows its sample's value; the first column of each sample after the
  // first also joins it to the previous sample's value with a vertical run.
  function automatic bit model_lit(bit idx, int px, int py, bit v);
    int c, rr, s, cur, oth, lo, hi;
    c  = px - XMIN;
    rr = py - YMIN;
    if (!v || c < 0 || c > 511 || rr < 0 || rr > 255) return 1'b0;
    s   = c / 2;
    cur = 255 - int'(mem[idx][s]);
    if (c == 0 || (c % 2) == 1) return (rr == cur);
    oth = 255 - int'(mem[idx][s-1]);
    lo  = (cur < oth) ? cur : oth;
    hi  = (cur < oth) ? oth : cur;
    return (rr >= lo) && (rr <= hi);
  endfunction

  task automatic step(input int px, input int py, input bit v);
    exp_t e;
    bit   inx, iny;
    logic [7:0] s;
    x     = px[10:0];
    y     = py[9:0];
    valid = v;
    inx = (px >= XMIN) && (px < XMIN + 512);
    iny = (py >= YMIN) && (py < YMIN + 256);
    if (!m_draw && v && iny) begin
      m_draw = 1'b1;
      m_idx  = read_index;
    end else if (m_draw && v && !iny) begin
      m_draw = 1'b0;
    end
    if (v && inx && iny) begin
      s      = 8'((px - XMIN) >> 1);
      m_addr = {m_idx, s};
    end
    e.vld = v;
    e.lit = model_lit(m_idx, px, py, v);
    e.px  = px;
    pipe_q.push_back(e);
    @(posedge clk);
    #1;
    check("idle", 32'(idle), 32'(!m_draw));
    check("read_address", 32'(read_address), 32'(m_addr));
    if (pipe_q.size() >= 2) begin
      e = pipe_q.pop_front();
      check("valid_pixel", 32'(valid_pixel), 32'(e.vld));
      check("rgb", 32'({r, g, b}), e.lit ? 32'hFFFFFF : 32'h0);
      obs_row[e.px] = ({r, g, b} == 24'hFFFFFF);
    end
  endtask

  task automatic blanks(input int py);
    int nb;
    nb = $urandom_range(1, 4);
    for (int i = 0; i < nb; i++) step(0, py, 1'b0);
  endtask

  task automatic scan_row(input int py);
    for (int i = 0; i < 2048; i++) obs_row[i] = 1'b0;
    for (int px = 60; px <= 580; px++) step(px, py, 1'b1);
    blanks(py);
  endtask

  task automatic model_reset();
    m_draw = 1'b0;
    m_idx  = 1'b0;
    m_addr = 9'd0;
    pipe_q.delete();
    pipe_q.push_back('{vld: 1'b0, lit: 1'b0, px: 0});
  endtask

  task automatic reset_mid();
    #2 rst = 1'b0;
    #1;
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_valid_pixel", 32'(valid_pixel), 32'd0);
    check("rst_rgb", 32'({r, g, b}), 32'd0);
    check("rst_read_address", 32'(read_address), 32'd0);
    valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  function automatic int count_lit();
    int cnt = 0;
    for (int i = 0; i < 2048; i++) cnt += int'(obs_row[i]);
    return cnt;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    x = '0; y = '0; valid = 1'b0; read_index = 1'b0;
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < 256; i++) mem[h][i] = 8'd128;

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    check("por_idle", 32'(idle), 32'd1);
    check("por_valid_pixel", 32'(valid_pixel), 32'd0);
    check("por_rgb", 32'({r, g, b}), 32'd0);
    check("por_read_address", 32'(read_address), 32'd0);
    rst = 1'b1;
    model_reset();

    // Flat value 128: only row YMIN+127 lights, across the full window width
    scan_row(111);
    scan_row(112);
    scan_row(150);
    scan_row(238);
    check("flat_row238_count", 32'(count_lit()), 32'd0);
    scan_row(239);
    check("flat_row239_count", 32'(count_lit()), 32'd512);
    check("flat_x63", 32'(obs_row[63]), 32'd0);
    check("flat_x64", 32'(obs_row[64]), 32'd1);
    check("flat_x575", 32'(obs_row[575]), 32'd1);
    check("flat_x576", 32'(obs_row[576]), 32'd0);
    scan_row(240);
    check("flat_row240_count", 32'(count_lit()), 32'd0);
    scan_row(367);
    scan_row(368);

    // Address map and a step between samples 3 and 4 in buffer 1
    mem[1][3] = 8'd10;
    mem[1][4] = 8'd200;
    read_index = 1'b1;
    for (int px = 60; px <= 580; px++) begin
      step(px, YMIN, 1'b1);
      if (px == XMIN + 7) check("addr_map", 32'(read_address), 32'h103);
    end
    blanks(YMIN);
    scan_row(YMIN + 54);
    check("step_r54_x72", 32'(obs_row[72]), 32'd0);
    scan_row(YMIN + 55);
    check("step_r55_x72", 32'(obs_row[72]), 32'd1);
    check("step_r55_x71", 32'(obs_row[71]), 32'd0);
    scan_row(YMIN + 245);
    check("step_r245_x72", 32'(obs_row[72]), 32'd1);
    check("step_r245_x71", 32'(obs_row[71]), 32'd1);
    check("step_r245_x73", 32'(obs_row[73]), 32'd0);
    scan_row(YMIN + 246);
    check("step_r246_x72", 32'(obs_row[72]), 32'd0);
    scan_row(368);

    // Reset in the middle of a window row, then resume mid-frame
    read_index = 1'b0;
    for (int px = 60; px <= 300; px++) step(px, 150, 1'b1);
    reset_mid();
    scan_row(150);
    scan_row(151);
    scan_row(368);

    // Swap guard: read_index toggles inside the window rows
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < 256; i++) mem[h][i] = 8'($urandom);
    read_index = 1'b0;
    scan_row(110);
    scan_row(112);
    scan_row(150);
    read_index = 1'b1;
    scan_row(YMIN + 100);
    scan_row(300);
    check("swap_hold_idx", 32'(read_address[8]), 32'd0);
    scan_row(367);
    scan_row(368);
    scan_row(369);
    scan_row(111);
    scan_row(112);
    check("swap_new_idx", 32'(read_address[8]), 32'd1);
    scan_row(200);
    scan_row(368);

    // Randomized frames
    for (int f = 0; f < 3; f++) begin
      for (int h = 0; h < 2; h++)
        for (int i = 0; i < 256; i++) mem[h][i] = 8'($urandom);
      for (int k = 0; k < 6; k++) begin
        read_index = 1'($urandom);
        scan_row(int'($urandom_range(100, 380)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
